axis_lrelu_config_framer: RTL and testbench

- Transmitter side of the LReLU engine's slave protocol.
- Merges a per-iteration config stream and a conv-output data stream into a single AXI-Stream. The stream carries config beats first (full width), then data beats, with tlast on the last data beat of each iteration.
- Sits between the conv core / config DMA and the LReLU engine.
- Registered output with a full skid buffer.

---
 rtl/axis_lrelu_config_framer_if.sv | 27 ++
 rtl/axis_lrelu_config_framer.sv | 179 +++++++++++++++++
 tb/tb_axis_lrelu_config_framer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_lrelu_config_framer_if.sv
// rtl/axis_lrelu_config_framer_if.sv - AXI-Stream bundle used by the LReLU config/data framer
interface axis_lrelu_config_framer_if #(
    parameter int TDATA_WIDTH = 2048,
    parameter int TUSER_WIDTH = 8
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;

    modport master (
        output tvalid,
        output tdata,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tuser,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_lrelu_config_framer.sv
// rtl/axis_lrelu_config_framer.sv - merges per-iteration config beats and conv data beats into one registered AXI-Stream
module axis_lrelu_config_framer #(
    parameter int TDATA_WIDTH      = 2048,
    parameter int TUSER_WIDTH      = 8,
    parameter int I_IS_1X1         = 5,
    parameter int CONFIG_BEATS_3X3 = 21,
    parameter int CONFIG_BEATS_1X1 = 13
) (
    input  logic                           aclk,
    input  logic                           areset,
    axis_lrelu_config_framer_if.slave      s_config,
    axis_lrelu_config_framer_if.slave      s_data,
    axis_lrelu_config_framer_if.master     m_axis,
    output logic                           config_err,
    output logic [15:0]                    iter_count
);

    localparam int CW = 8;
    localparam logic [CW-1:0] LOAD_3X3 = CW'(CONFIG_BEATS_3X3 - 2);
    localparam logic [CW-1:0] LOAD_1X1 = CW'(CONFIG_BEATS_1X1 - 2);

    typedef enum logic [1:0] {
        CFG_FIRST_S = 2'd0,
        CFG_REST_S  = 2'd1,
        DATA_S      = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic                   mode_q;

    // Skid buffer: main register drives m_axis, skid register catches a beat accepted while stalled
    logic                   out_valid_q;
    logic [TDATA_WIDTH-1:0] out_data_q;
    logic [TUSER_WIDTH-1:0] out_user_q;
    logic                   out_last_q;
    logic                   skid_valid_q;
    logic                   skid_valid_d;
    logic [TDATA_WIDTH-1:0] skid_data_q;
    logic [TUSER_WIDTH-1:0] skid_user_q;
    logic                   skid_last_q;
    logic                   rdy_q;

    logic                   cfg_sel;
    logic                   hs;
    logic [TDATA_WIDTH-1:0] in_data;
    logic [TUSER_WIDTH-1:0] in_user;
    logic                   in_last;
    logic                   cnt_last;
    logic                   out_free;

    assign cnt_last = (cnt_q == '0);
    assign out_free = !out_valid_q || m_axis.tready;

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= CFG_FIRST_S;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: first config beat, counted remaining config beats, then data until tlast
    always_comb begin
        state_d = state_q;
        case (state_q)
            CFG_FIRST_S: if (hs) state_d = CFG_REST_S;
            CFG_REST_S:  if (hs && cnt_last) state_d = DATA_S;
            DATA_S:      if (hs && s_data.tlast) state_d = CFG_FIRST_S;
            default:     state_d = CFG_FIRST_S;
        endcase
    end

    // Output decode: route exactly one input to the buffer and hold the other off
    always_comb begin
        cfg_sel         = (state_q != DATA_S);
        s_config.tready = cfg_sel && rdy_q;
        s_data.tready   = !cfg_sel && rdy_q;
        hs              = cfg_sel ? (s_config.tvalid && rdy_q) : (s_data.tvalid && rdy_q);
        in_data         = cfg_sel ? s_config.tdata : s_data.tdata;
        in_user         = cfg_sel ? s_config.tuser : s_data.tuser;
        in_last         = cfg_sel ? 1'b0 : s_data.tlast;
        if (!cfg_sel) begin
            in_user[I_IS_1X1] = mode_q;
        end
    end

    // Beat counter and mode latch: mode comes from beat 0, counter tracks remaining config beats
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else if (hs) begin
            if (state_q == CFG_FIRST_S) begin
                mode_q <= s_config.tuser[I_IS_1X1];
                cnt_q  <= s_config.tuser[I_IS_1X1] ? LOAD_1X1 : LOAD_3X3;
            end else if (state_q == CFG_REST_S) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Sticky framing error: sender's tlast must land exactly on the final counted config beat
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            config_err <= 1'b0;
        end else if (hs) begin
            if (state_q == CFG_FIRST_S && s_config.tlast) begin
                config_err <= 1'b1;
            end else if (state_q == CFG_REST_S && (s_config.tlast != cnt_last)) begin
                config_err <= 1'b1;
            end
        end
    end

    // Completed-iteration counter, wraps naturally at 16 bits
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            iter_count <= '0;
        end else if (hs && state_q == DATA_S && s_data.tlast) begin
            iter_count <= iter_count + 16'd1;
        end
    end

    // Skid occupancy after this cycle; rdy follows it one cycle later
    always_comb begin
        skid_valid_d = skid_valid_q;
        if (out_free) begin
            skid_valid_d = 1'b0;
        end else if (hs) begin
            skid_valid_d = 1'b1;
        end
    end

    // Skid buffer datapath: refill main from skid first, otherwise from the accepted beat
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_user_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_user_q  <= '0;
            skid_last_q  <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            if (out_free) begin
                if (skid_valid_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= skid_data_q;
                    out_user_q  <= skid_user_q;
                    out_last_q  <= skid_last_q;
                end else begin
                    out_valid_q <= hs;
                    if (hs) begin
                        out_data_q <= in_data;
                        out_user_q <= in_user;
                        out_last_q <= in_last;
                    end
                end
            end else if (hs) begin
                skid_data_q <= in_data;
                skid_user_q <= in_user;
                skid_last_q <= in_last;
            end
            skid_valid_q <= skid_valid_d;
            rdy_q        <= !skid_valid_d;
        end
    end

    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tuser  = out_user_q;
    assign m_axis.tlast  = out_last_q;

endmodule

// File: tb/tb_axis_lrelu_config_framer.sv
// tb/tb_axis_lrelu_config_framer.sv - scoreboard bench for the LReLU config/data framer
`timescale 1ns/1ps
module tb_axis_lrelu_config_framer;

    localparam int DW = 64;
    localparam int UW = 8;
    localparam int IB = 5;
    localparam int N3 = 21;
    localparam int N1 = 13;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        config_err;
    logic [15:0] iter_count;

    always #5 aclk = ~aclk;

    axis_lrelu_config_framer_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) cfg_if ();
    axis_lrelu_config_framer_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) dat_if ();
    axis_lrelu_config_framer_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) out_if ();

    axis_lrelu_config_framer #(
        .TDATA_WIDTH      (DW),
        .TUSER_WIDTH      (UW),
        .I_IS_1X1         (IB),
        .CONFIG_BEATS_3X3 (N3),
        .CONFIG_BEATS_1X1 (N1)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_config   (cfg_if),
        .s_data     (dat_if),
        .m_axis     (out_if),
        .config_err (config_err),
        .iter_count (iter_count)
    );

    int    vectors = 0;
    int    miscompares = 0;
    beat_t cfg_q[$];
    beat_t dat_q[$];
    beat_t exp_q[$];
    int    iters_cfg[$];
    bit    cfg_hs = 0, dat_hs = 0;
    bit    flush = 0, gaps = 0, rnd_ready = 0, meas = 0;
    int    cfg_in_iter = 0, data_iter_done = 0, dat_acc_total = 0;
    int    cyc = 0, meas_n = 0, meas_first = 0, meas_last = 0;
    bit    prev_stall = 0;
    beat_t prev_beat;

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: an iteration is its mode's config beats followed by its data beats,
    // data tuser carrying the mode in bit IB and config beats never marked last.
    task automatic gen_iter(bit mode, int ndata, int bad_pos);
        int    n;
        beat_t b;
        n = mode ? N1 : N3;
        for (int i = 0; i < n; i++) begin
            b.d = {$urandom, $urandom};
            b.u = UW'($urandom);
            if (i == 0) b.u[IB] = mode;
            b.l = (bad_pos != 0) ? (i == bad_pos - 1) : (i == n - 1);
            cfg_q.push_back(b);
            b.l = 1'b0;
            exp_q.push_back(b);
        end
        for (int i = 0; i < ndata; i++) begin
            b.d = {$urandom, $urandom};
            b.u = UW'($urandom);
            b.l = (i == ndata - 1);
            dat_q.push_back(b);
            b.u[IB] = mode;
            exp_q.push_back(b);
        end
        iters_cfg.push_back(n);
    endtask

    task automatic wait_drain(string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || cfg_q.size() > 0 || dat_q.size() > 0) && n < 5000) begin
            @(posedge aclk);
            n++;
        end
        chk({"drain_", name}, 128'(n < 5000), 128'(1));
        repeat (3) @(posedge aclk);
    endtask

    // Config source driver
    initial begin
        cfg_if.tvalid = 1'b0;
        cfg_if.tdata  = '0;
        cfg_if.tuser  = '0;
        cfg_if.tlast  = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            if (flush) begin
                cfg_q.delete();
                cfg_if.tvalid = 1'b0;
            end else begin
                if (cfg_hs && cfg_q.size() > 0) void'(cfg_q.pop_front());
                if (!(cfg_if.tvalid && !cfg_hs)) begin
                    if (cfg_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                        cfg_if.tvalid = 1'b1;
                        {cfg_if.tdata, cfg_if.tuser, cfg_if.tlast} = cfg_q[0];
                    end else begin
                        cfg_if.tvalid = 1'b0;
                    end
                end
            end
        end
    end

    // Data source driver
    initial begin
        dat_if.tvalid = 1'b0;
        dat_if.tdata  = '0;
        dat_if.tuser  = '0;
        dat_if.tlast  = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            if (flush) begin
                dat_q.delete();
                dat_if.tvalid = 1'b0;
            end else begin
                if (dat_hs && dat_q.size() > 0) void'(dat_q.pop_front());
                if (!(dat_if.tvalid && !dat_hs)) begin
                    if (dat_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                        dat_if.tvalid = 1'b1;
                        {dat_if.tdata, dat_if.tuser, dat_if.tlast} = dat_q[0];
                    end else begin
                        dat_if.tvalid = 1'b0;
                    end
                end
            end
        end
    end

    // Downstream ready: always high, or roughly 30% duty
    initial begin
        out_if.tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            out_if.tready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Monitor: input gating, output stability and scoreboard pops
    initial begin
        beat_t cur, e;
        int    k;
        forever begin
            @(negedge aclk);
            cyc++;
            cfg_hs = cfg_if.tvalid && cfg_if.tready;
            dat_hs = dat_if.tvalid && dat_if.tready;
            cur = {out_if.tdata, out_if.tuser, out_if.tlast};
            if (areset) begin
                cfg_in_iter    = 0;
                data_iter_done = 0;
                prev_stall     = 0;
            end else begin
                k = data_iter_done;
                if (k < iters_cfg.size()) begin
                    if (cfg_if.tready) chk("cfg_ready_gate", 128'(cfg_in_iter < iters_cfg[k]), 128'(1));
                    if (dat_if.tready) chk("data_ready_gate", 128'(cfg_in_iter), 128'(iters_cfg[k]));
                end
                if (cfg_hs) cfg_in_iter++;
                if (dat_hs) begin
                    dat_acc_total++;
                    if (dat_if.tlast) begin
                        cfg_in_iter = 0;
                        data_iter_done++;
                    end
                end
                if (prev_stall) begin
                    chk("stall_valid", 128'(out_if.tvalid), 128'(1));
                    chk("stall_beat", 128'(cur), 128'(prev_beat));
                end
                if (out_if.tvalid && out_if.tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 128'(cur), 128'(0));
                        if (cur == '0) chk("unexpected_beat_any", 128'(1), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 128'(cur), 128'(e));
                        if (meas) begin
                            if (meas_n == 0) meas_first = cyc;
                            meas_last = cyc;
                            meas_n++;
                        end
                    end
                end
                prev_stall = out_if.tvalid && !out_if.tready;
                prev_beat  = cur;
            end
        end
    end

    // Main sequence
    initial begin
        int start, n;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #2;
        chk("rst_tvalid", 128'(out_if.tvalid), 128'(0));
        chk("rst_tdata", 128'(out_if.tdata), 128'(0));
        chk("rst_tuser", 128'(out_if.tuser), 128'(0));
        chk("rst_tlast", 128'(out_if.tlast), 128'(0));
        chk("rst_config_err", 128'(config_err), 128'(0));
        chk("rst_iter_count", 128'(iter_count), 128'(0));
        chk("rst_cfg_tready", 128'(cfg_if.tready), 128'(0));
        chk("rst_dat_tready", 128'(dat_if.tready), 128'(0));
        @(negedge aclk);
        areset = 1'b0;

        // Full-rate: 3x3 with 50 data, 1x1 with 8 data, 3x3 with a 1-beat iteration
        meas = 1;
        gen_iter(1'b0, 50, 0);
        gen_iter(1'b1, 8, 0);
        gen_iter(1'b0, 1, 0);
        wait_drain("full_rate");
        meas = 0;
        chk("beat_count", 128'(meas_n), 128'(71 + 21 + 22));
        chk("no_bubble", 128'(meas_last - meas_first), 128'(meas_n - 1));
        chk("iter_count_p1", 128'(iter_count), 128'(3));
        chk("config_err_p1", 128'(config_err), 128'(0));

        // Backpressure and source gaps
        gaps = 1;
        rnd_ready = 1;
        gen_iter(1'b0, 30, 0);
        gen_iter(1'b1, 12, 0);
        for (int i = 0; i < 3; i++) gen_iter(1'($urandom_range(0, 1)), $urandom_range(1, 20), 0);
        wait_drain("backpressure");
        chk("iter_count_p2", 128'(iter_count), 128'(8));
        chk("config_err_p2", 128'(config_err), 128'(0));

        // Bad framing: tlast on config beat 20 of 21, framing still counted
        gen_iter(1'b0, 5, 20);
        gen_iter(1'b1, 3, 0);
        wait_drain("bad_framing");
        chk("config_err_p3", 128'(config_err), 128'(1));
        chk("iter_count_p3", 128'(iter_count), 128'(10));

        // Reset in the middle of data
        gaps = 0;
        rnd_ready = 0;
        gen_iter(1'b0, 30, 0);
        start = dat_acc_total;
        n = 0;
        while (dat_acc_total - start < 10 && n < 2000) begin
            @(posedge aclk);
            n++;
        end
        chk("mid_data_reached", 128'(n < 2000), 128'(1));
        @(posedge aclk);
        #2;
        areset = 1'b1;
        flush  = 1'b1;
        #1;
        chk("mid_rst_tvalid", 128'(out_if.tvalid), 128'(0));
        chk("mid_rst_iter_count", 128'(iter_count), 128'(0));
        chk("mid_rst_config_err", 128'(config_err), 128'(0));
        chk("mid_rst_cfg_tready", 128'(cfg_if.tready), 128'(0));
        chk("mid_rst_dat_tready", 128'(dat_if.tready), 128'(0));
        exp_q.delete();
        iters_cfg.delete();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        flush  = 1'b0;
        gen_iter(1'b1, 4, 0);
        wait_drain("after_reset");
        chk("iter_count_p4", 128'(iter_count), 128'(1));
        chk("config_err_p4", 128'(config_err), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
